// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants, FSM state type and hex segment table for the seven-segment driver
package sseg_pkg;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;
  typedef enum logic {BLANK, SHOW} sseg_state_t;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/sseg_scan_driver_hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder
module hex_to_seg
  import sseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: 4-digit multiplexed seven-segment driver with frame-synchronous double buffering; define SSEG_BLANK_EN for per-slot blanking
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int BLANK_CYC = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_start
);
`ifdef SSEG_BLANK_EN
  localparam int BLANK_ON = 1;
`else
  localparam int BLANK_ON = 0;
`endif
  localparam int BLANK_LEN = BLANK_ON * BLANK_CYC;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [1:0] idx, idx_n;
  logic [15:0] pend, act, act_n;
  logic dirty, slot_end, frame_end;
  logic [3:0] nib, an_n;
  logic [6:0] dec, seg_n;
  sseg_state_t state, state_n;
  // outputs are registered from next-cycle values so they line up with cnt/idx/state
  always_comb begin
    slot_end = &cnt;
    frame_end = slot_end && idx == 2'd3;
    cnt_n = cnt + DIV_W'(1);
    idx_n = idx + {1'b0, slot_end};
    act_n = frame_end ? (load ? digits_in : pend) : act;
    nib = act_n[{idx_n, 2'b00} +: 4];
  end
  hex_to_seg u_dec (.nib(nib), .seg(dec));
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BLANK;
    else state <= state_n;
  end
  // next state: blank at the start of every slot, show once the blank window has elapsed
  always_comb begin
    state_n = (BLANK_LEN == 0) ? SHOW :
              slot_end ? BLANK :
              (state == BLANK && cnt == DIV_W'(BLANK_LEN - 1)) ? SHOW : state;
  end
  // output decode for the upcoming cycle
  always_comb begin
    an_n = (state_n == SHOW) ? ~(4'b0001 << idx_n) : AN_OFF;
    seg_n = (state_n == SHOW) ? dec : SEG_OFF;
  end
  // scan counters, double buffer and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      pend <= '0;
      act <= '0;
      dirty <= 1'b0;
      an <= AN_OFF;
      seg <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      cnt <= cnt_n;
      idx <= idx_n;
      act <= act_n;
      if (load) pend <= digits_in;
      dirty <= frame_end ? 1'b0 : (dirty || load);
      an <= an_n;
      seg <= seg_n;
      frame_start <= frame_end && (dirty || load);
    end
  end
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: directed and randomized checks of sseg_scan_driver against a cycle-count reference model
module tb_sseg_scan_driver;
  localparam int SLOT = 16;
  localparam int BCYC = 3;
`ifdef SSEG_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic frame_start;
  int tests = 0;
  int fails = 0;
  int t = 0;
  logic [15:0] m_pend, m_act;
  logic m_dirty, m_fs;
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  always #5 clk = ~clk;
  sseg_scan_driver #(.DIV_W(4), .BLANK_CYC(BCYC)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
    .an(an), .seg(seg), .frame_start(frame_start)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_outputs(input string tag);
    int c, i;
    logic blank;
    logic [3:0] ea, nib;
    logic [6:0] es;
    c = t % SLOT;
    i = (t / SLOT) % 4;
    blank = (t == 0) || (BLK && c < BCYC);
    nib = m_act[4*i +: 4];
    ea = blank ? 4'hF : ~(4'b0001 << i);
    es = blank ? 7'h7F : tbl[nib];
    check({tag, " an"}, 16'(an), 16'(ea));
    check({tag, " seg"}, 16'(seg), 16'(es));
    check({tag, " frame_start"}, 16'(frame_start), 16'(m_fs));
  endtask
  task automatic tick(input logic ld, input logic [15:0] val);
    bit frame;
    load = ld;
    digits_in = val;
    @(posedge clk);
    frame = (t % 64) == 63;
    m_fs = frame && (m_dirty || ld);
    if (frame) begin
      m_act = ld ? val : m_pend;
      m_dirty = 1'b0;
    end else if (ld) m_dirty = 1'b1;
    if (ld) m_pend = val;
    t++;
    #1;
    check_outputs("step");
  endtask
  task automatic run_until(input int target);
    for (int k = 0; k < 64 && (t % 64) != target; k++) tick(1'b0, 16'($urandom));
  endtask
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    load = 1'b0;
    #1;
    check({tag, " an"}, 16'(an), 16'hF);
    check({tag, " seg"}, 16'(seg), 16'h7F);
    check({tag, " frame_start"}, 16'(frame_start), 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    t = 0;
    m_pend = '0;
    m_act = '0;
    m_dirty = 1'b0;
    m_fs = 1'b0;
    check_outputs("post_reset");
  endtask
  initial begin
    do_reset("reset");
    for (int k = 0; k < 16; k++) tick(1'b0, 16'hFFFF);
    run_until(20);
    tick(1'b1, 16'h12AF);
    run_until(60);
    check("old_digit3_seg", 16'(seg), 16'h40);
    run_until(0);
    check("midload_fs", 16'(frame_start), 16'h1);
    run_until(5);
    check("midload_d0_an", 16'(an), 16'hE);
    check("midload_d0_seg", 16'(seg), 16'h0E);
    run_until(21);
    check("midload_d1_seg", 16'(seg), 16'h08);
    run_until(53);
    check("midload_d3_seg", 16'(seg), 16'h79);
    run_until(63);
    tick(1'b1, 16'h8888);
    check("bndload_fs", 16'(frame_start), 16'h1);
    run_until(5);
    check("bndload_d0_seg", 16'(seg), 16'h00);
    run_until(0);
    check("clean_fs", 16'(frame_start), 16'h0);
    run_until(20);
    tick(1'b1, 16'h1111);
    tick(1'b1, 16'h2222);
    run_until(0);
    check("b2b_fs", 16'(frame_start), 16'h1);
    for (int d = 0; d < 4; d++) begin
      run_until(16 * d + 5);
      check("b2b_seg", 16'(seg), 16'h24);
    end
    for (int k = 0; k < 400; k++) tick($urandom_range(0, 7) == 0, 16'($urandom));
    run_until(39);
    check("pre_reset_an", 16'(an), 16'hB);
    do_reset("midslot_reset");
    for (int k = 0; k < 200; k++) tick($urandom_range(0, 5) == 0, 16'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
